// File: rtl/led_pkg.sv
// Shared constants, level type and saturating level arithmetic for the LED fade driver.
package led_pkg;

   localparam int N_LED    = 4;
   localparam int PWM_BITS = 4;
   localparam int MAX      = (1 << PWM_BITS) - 1;

   localparam logic [N_LED-1:0] LED_ALL_OFF = '1;

   typedef logic [PWM_BITS-1:0] level_t;
   typedef logic [PWM_BITS:0]   level_wide_t;

   localparam level_wide_t MAX_W = level_wide_t'(MAX);

   function automatic level_t sat_add(input level_t a, input level_t b);
      level_wide_t s;
      s = {1'b0, a} + {1'b0, b};
      if (s > MAX_W)
         return level_t'(MAX);
      return s[PWM_BITS-1:0];
   endfunction

   // A borrow out of the extra bit means the result went negative.
   function automatic level_t sat_sub(input level_t a, input level_t b);
      level_wide_t d;
      d = {1'b0, a} - {1'b0, b};
      if (d[PWM_BITS])
         return '0;
      return d[PWM_BITS-1:0];
   endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// Pattern-in / LED-out signal bundle of the LED fade driver.
interface led_fade_driver_if;
   import led_pkg::*;

   logic                      en;
   logic [N_LED-1:0]          pattern_n;
   logic [N_LED-1:0]          led_n;
   logic [N_LED*PWM_BITS-1:0] level;
   logic                      period_tick;

   modport master (
      output en,
      output pattern_n,
      input  led_n,
      input  level,
      input  period_tick
   );

   modport slave (
      input  en,
      input  pattern_n,
      output led_n,
      output level,
      output period_tick
   );
endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level register with saturating ramp and registered PWM compare.
module led_fade_channel
   import led_pkg::*;
#(
   parameter int ATTACK = 15,
   parameter int DECAY  = 3
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_en,
   input  logic   i_ramp_tick,
   input  logic   i_sync_n,
   input  level_t i_pwm_cnt,
   output level_t o_level,
   output logic   o_led_n
);

   localparam level_t ATTACK_L = level_t'(ATTACK);
   localparam level_t DECAY_L  = level_t'(DECAY);

   level_t r_level;
   level_t w_level_next;
   logic   r_led_n;
   logic   w_led_n_next;

   always_comb begin
      w_level_next = r_level;
      w_led_n_next = 1'b1;
      if (!i_en) begin
         w_level_next = '0;
      end else begin
         // Compare uses the level of the current period; new level lands at the boundary.
         w_led_n_next = ~(r_level > i_pwm_cnt);
         if (i_ramp_tick)
            w_level_next = i_sync_n ? sat_sub(r_level, DECAY_L)
                                    : sat_add(r_level, ATTACK_L);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= '0;
         r_led_n <= 1'b1;
      end else begin
         r_level <= w_level_next;
         r_led_n <= w_led_n_next;
      end
   end

   assign o_level = r_level;
   assign o_led_n = r_led_n;

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver top: pattern synchroniser, PWM/period counters and the per-channel fade stages.
module led_fade_driver
   import led_pkg::*;
#(
   parameter int RAMP_DIV = 4,
   parameter int ATTACK   = 15,
   parameter int DECAY    = 3
) (
   input logic              clk,
   input logic              rst_n,
   led_fade_driver_if.slave bus
);

   localparam int PER_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   localparam level_t            PWM_LAST = level_t'(MAX - 1);
   localparam logic [PER_W-1:0]  PER_LAST = PER_W'(RAMP_DIV - 1);

   logic [N_LED-1:0] r_sync1;
   logic [N_LED-1:0] r_sync2;
   level_t           r_pwm_cnt;
   logic [PER_W-1:0] r_per_cnt;
   logic             r_period_tick;
   logic             w_pwm_last;
   logic             w_ramp_tick;
   logic [N_LED-1:0] w_led_n;

   // The synchroniser ignores en so a freshly enabled block sees a settled pattern.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= LED_ALL_OFF;
         r_sync2 <= LED_ALL_OFF;
      end else begin
         r_sync1 <= bus.pattern_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_pwm_last  = (r_pwm_cnt == PWM_LAST);
   assign w_ramp_tick = bus.en && w_pwm_last && (r_per_cnt == PER_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_cnt     <= '0;
         r_per_cnt     <= '0;
         r_period_tick <= 1'b0;
      end else if (!bus.en) begin
         r_pwm_cnt     <= '0;
         r_per_cnt     <= '0;
         r_period_tick <= 1'b0;
      end else begin
         r_period_tick <= w_pwm_last;
         if (w_pwm_last) begin
            r_pwm_cnt <= '0;
            r_per_cnt <= (r_per_cnt == PER_LAST) ? '0 : r_per_cnt + 1'b1;
         end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N_LED; gi++) begin : g_chan
         led_fade_channel #(
            .ATTACK (ATTACK),
            .DECAY  (DECAY)
         ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_en        (bus.en),
            .i_ramp_tick (w_ramp_tick),
            .i_sync_n    (r_sync2[gi]),
            .i_pwm_cnt   (r_pwm_cnt),
            .o_level     (bus.level[gi*PWM_BITS +: PWM_BITS]),
            .o_led_n     (w_led_n[gi])
         );
      end
   endgenerate

   assign bus.led_n       = w_led_n;
   assign bus.period_tick = r_period_tick;

endmodule
